// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan capture block:
// segment patterns (a..g, active low), digit strobes, frame states, error causes.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  localparam logic [3:0] SEL_SEC_ONES = 4'b0001;
  localparam logic [3:0] SEL_SEC_TENS = 4'b0010;
  localparam logic [3:0] SEL_MIN_ONES = 4'b0100;
  localparam logic [3:0] SEL_MIN_TENS = 4'b1000;

  typedef enum logic [1:0] {HUNT, D1, D2, D3} frame_state_e;

  typedef enum logic [1:0] {
    ERR_PATTERN = 2'd0,
    ERR_SEL     = 2'd1,
    ERR_ORDER   = 2'd2,
    ERR_RANGE   = 2'd3
  } err_code_e;

  // tens*10 + ones using shifts; inputs are range-checked BCD so 6 bits suffice.
  function automatic logic [5:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    logic [5:0] t;
    t = {2'b00, tens};
    return (t << 3) + (t << 1) + {2'b00, ones};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment to BCD decoder; dp is not part of the pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       valid
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    digit = 4'd0;
    valid = 1'b1;
    case (pattern)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Captures a multiplexed 4-digit mm:ss seven-segment display into BCD and binary,
// with settle filtering, frame ordering checks, error reporting and a stale flag.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [3:0]  digit_sel,
  input  logic [7:0]  seven_seg,
  output logic [15:0] digits,
  output logic [5:0]  sec,
  output logic [5:0]  min,
  output logic        frame_valid,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        stale
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [11:0]   sync1, sync2, prev;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] timeout_cnt;
  logic          changed, settle_hit, capture;
  logic [3:0]    sel_s;
  logic [3:0]    dec_digit;
  logic          dec_valid, sel_onehot;

  frame_state_e  state, state_n;
  logic [3:0]    shadow [3];
  logic [2:0]    wr_shadow;
  logic          do_update, do_err;
  err_code_e     err_n, err_code_q;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= {digit_sel, seven_seg};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign changed    = (sync2 != prev);
  assign settle_hit = !changed && (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign sel_s      = sync2[11:8];
  assign sel_onehot = (sel_s != 4'd0) && ((sel_s & (sel_s - 4'd1)) == 4'd0);
  assign capture    = settle_hit && (sel_s != 4'd0);

  // Saturating at SETTLE_CYCLES guarantees one capture per stable interval.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                                    settle_cnt <= '0;
    else if (changed)                           settle_cnt <= '0;
    else if (settle_cnt != SW'(SETTLE_CYCLES))  settle_cnt <= settle_cnt + 1'b1;
  end

  seg7_decode u_decode (
    .pattern (sync2[7:1]),
    .digit   (dec_digit),
    .valid   (dec_valid)
  );

  always_comb begin
    state_n   = state;
    wr_shadow = 3'b000;
    do_update = 1'b0;
    do_err    = 1'b0;
    err_n     = ERR_PATTERN;
    if (capture) begin
      if (!sel_onehot) begin
        do_err  = 1'b1;
        err_n   = ERR_SEL;
        state_n = HUNT;
      end else if (!dec_valid) begin
        do_err  = 1'b1;
        err_n   = ERR_PATTERN;
        state_n = HUNT;
      end else begin
        case (state)
          HUNT: if (sel_s == SEL_SEC_ONES) begin
            wr_shadow = 3'b001;
            state_n   = D1;
          end
          D1: begin
            if (sel_s == SEL_SEC_ONES)      wr_shadow = 3'b001;
            else if (sel_s == SEL_SEC_TENS) begin wr_shadow = 3'b010; state_n = D2; end
            else begin do_err = 1'b1; err_n = ERR_ORDER; state_n = HUNT; end
          end
          D2: begin
            if (sel_s == SEL_SEC_TENS)      wr_shadow = 3'b010;
            else if (sel_s == SEL_MIN_ONES) begin wr_shadow = 3'b100; state_n = D3; end
            else if (sel_s == SEL_SEC_ONES) begin
              wr_shadow = 3'b001; do_err = 1'b1; err_n = ERR_ORDER; state_n = D1;
            end else begin do_err = 1'b1; err_n = ERR_ORDER; state_n = HUNT; end
          end
          default: begin
            if (sel_s == SEL_MIN_ONES)      wr_shadow = 3'b100;
            else if (sel_s == SEL_MIN_TENS) begin
              state_n = HUNT;
              if (shadow[1] <= 4'd5 && dec_digit <= 4'd5) do_update = 1'b1;
              else begin do_err = 1'b1; err_n = ERR_RANGE; end
            end else if (sel_s == SEL_SEC_ONES) begin
              wr_shadow = 3'b001; do_err = 1'b1; err_n = ERR_ORDER; state_n = D1;
            end else begin do_err = 1'b1; err_n = ERR_ORDER; state_n = HUNT; end
          end
        endcase
      end
    end
  end

  // NOTE: the shadow digits are reset with everything else so a frame cut by
  // reset can never leak stale digits into the next one.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      shadow[0]   <= '0;
      shadow[1]   <= '0;
      shadow[2]   <= '0;
      digits      <= '0;
      sec         <= '0;
      min         <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      err_code_q  <= ERR_PATTERN;
    end else begin
      state       <= state_n;
      frame_valid <= do_update;
      err         <= do_err;
      if (do_err) err_code_q <= err_n;
      for (int i = 0; i < 3; i++)
        if (wr_shadow[i]) shadow[i] <= dec_digit;
      if (do_update) begin
        digits <= {dec_digit, shadow[2], shadow[1], shadow[0]};
        sec    <= bcd_to_bin(shadow[1], shadow[0]);
        min    <= bcd_to_bin(dec_digit, shadow[2]);
      end
    end
  end

  assign err_code = err_code_q;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      timeout_cnt <= '0;
      stale       <= 1'b0;
    end else begin
      if (capture)                                  timeout_cnt <= '0;
      else if (timeout_cnt != TW'(TIMEOUT_CYCLES))  timeout_cnt <= timeout_cnt + 1'b1;
      if (frame_valid)                              stale <= 1'b0;
      else if (timeout_cnt == TW'(TIMEOUT_CYCLES))  stale <= 1'b1;
    end
  end

endmodule
